// File: rtl/systolic_pkg.sv
// Shared systolic-path types and default widths; the Macro.svh width macros fall back to
// the values below when not supplied by the build. WRITEBACK_RELU_EN selects writeback ReLU.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 8
`endif

package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wb_state_t;

    localparam int SA_ROWS = 8;
    localparam int SA_COLS = 8;

    typedef logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0] beat_t;

endpackage

// File: rtl/relu_lane.sv
// One combinational ReLU lane: negative (MSB set) inputs become zero, zero latency, no backpressure.
// Only compiled into the build when WRITEBACK_RELU_EN is defined.
`ifdef WRITEBACK_RELU_EN
module relu_lane #(
    parameter int W = 16
) (
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = din[W-1] ? '0 : din;

endmodule
`endif

// File: rtl/systolic_result_writer.sv
// Snapshots the result matrix on start and writes it row-major, one beat per cycle from the cycle after start;
// a low wr_ready freezes the beat in place. WRITEBACK_RELU_EN clamps negative lanes to zero on the data mux.
module systolic_result_writer
    import systolic_pkg::*;
#(
    parameter int ROWS = SA_ROWS,
    parameter int COLS = SA_COLS
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [`ADDR_WIDTH-1:0]                     base_C,
    input  logic [`DIM_WIDTH-1:0]                      dim_col_C,
    input  logic [ROWS-1:0][COLS-1:0][`DATA_WIDTH-1:0] Out,
    output logic                                       write,
    output logic [`ADDR_WIDTH-1:0]                     write_addr,
    output beat_t                                      writedata,
    input  logic                                       wr_ready,
    output logic                                       busy,
    output logic                                       done
);

    localparam int BW     = `BANDWIDTH;
    localparam int AW     = `ADDR_WIDTH;
    localparam int DW     = `DATA_WIDTH;
    localparam int BEATS  = COLS / BW;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (COLS % BW != 0) begin : g_bad_cols
        $error("systolic_result_writer: COLS must be a multiple of BANDWIDTH");
    end

    typedef logic [ROWS-1:0][COLS-1:0][DW-1:0] mat_t;
    typedef logic [BEATS-1:0][BW-1:0][DW-1:0]  row_t;

    wb_state_t          state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [AW-1:0]      row_base_q, row_base_d;
    logic [AW-1:0]      dim_q, dim_d;
    mat_t               snap_q, snap_d;
    logic               write_q, write_d;
    logic [AW-1:0]      addr_q, addr_d;
    beat_t              data_q, data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    row_t               row_sel;
    beat_t              raw_dat;
    beat_t              lane_dat;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        beat_d     = beat_q;
        row_base_d = row_base_q;
        dim_d      = dim_q;
        snap_d     = snap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d     = Out;
                    dim_d      = AW'(dim_col_C);
                    row_d      = '0;
                    beat_d     = '0;
                    row_base_d = base_C;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        beat_d     = '0;
                        row_base_d = row_base_q + dim_q;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The beat is selected from next-state counters so the registered outputs line up with them.
    assign row_sel = snap_d[row_d];
    assign raw_dat = row_sel[beat_d];

`ifdef WRITEBACK_RELU_EN
    for (genvar k = 0; k < BW; k++) begin : g_relu
        relu_lane #(.W(DW)) u_relu_lane (
            .din  (raw_dat[k]),
            .dout (lane_dat[k])
        );
    end
`else
    assign lane_dat = raw_dat;
`endif

    always_comb begin
        write_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        addr_d  = addr_q;
        data_d  = data_q;
        if (state_d == WRITE) begin
            addr_d = row_base_d + AW'(beat_d) * AW'(BW);
            data_d = lane_dat;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            beat_q     <= '0;
            row_base_q <= '0;
            dim_q      <= '0;
            snap_q     <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            beat_q     <= beat_d;
            row_base_q <= row_base_d;
            dim_q      <= dim_d;
            snap_q     <= snap_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign write      = write_q;
    assign write_addr = addr_q;
    assign writedata  = data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_result_writer.sv
// Bench for systolic_result_writer: queue-based reference of expected beats, per-cycle compare.
module tb_systolic_result_writer;
    import systolic_pkg::*;

    localparam int AW    = `ADDR_WIDTH;
    localparam int DW    = `DATA_WIDTH;
    localparam int BW    = `BANDWIDTH;
    localparam int DIMW  = `DIM_WIDTH;
    localparam int BEATS = SA_COLS / BW;

    typedef logic [SA_ROWS-1:0][SA_COLS-1:0][DW-1:0] mat_t;
    typedef struct {
        logic [AW-1:0] addr;
        beat_t         dat;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic            wr_ready = 1'b1;
    logic [AW-1:0]   base_C = '0;
    logic [DIMW-1:0] dim_col_C = '0;
    mat_t            out_m = '0;

    logic            write;
    logic            busy;
    logic            done;
    logic [AW-1:0]   write_addr;
    beat_t           writedata;

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   rdy_mode = 0;
    int   rdy_ph   = 0;
    exp_t exp_q[$];
    bit   m_done   = 1'b0;

    always #5 clock = ~clock;

    systolic_result_writer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_C     (base_C),
        .dim_col_C  (dim_col_C),
        .Out        (out_m),
        .write      (write),
        .write_addr (write_addr),
        .writedata  (writedata),
        .wr_ready   (wr_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_lane(input logic [DW-1:0] v);
`ifdef WRITEBACK_RELU_EN
        return v[DW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Expected beats straight from the address/data rules, using the inputs seen at start.
    task automatic load_transfer();
        exp_t e;
        for (int r = 0; r < SA_ROWS; r++) begin
            for (int b = 0; b < BEATS; b++) begin
                e.addr = AW'(int'(base_C) + r * int'(dim_col_C) + b * BW);
                for (int k = 0; k < BW; k++) e.dat[k] = model_lane(out_m[r][b*BW+k]);
                exp_q.push_back(e);
            end
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (exp_q.size() != 0) begin
                if (wr_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) m_done = 1'b1;
                end
            end else if (start) begin
                load_transfer();
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            exp_q.delete();
            m_done = 1'b0;
            check("rst_write", 64'(write), 64'd0);
            check("rst_busy",  64'(busy),  64'd0);
            check("rst_done",  64'(done),  64'd0);
            check("rst_addr",  64'(write_addr), 64'd0);
            check("rst_data",  64'(writedata),  64'd0);
        end else begin
            check("write", 64'(write), 64'(exp_q.size() != 0));
            check("busy",  64'(busy),  64'((exp_q.size() != 0) || m_done));
            check("done",  64'(done),  64'(m_done));
            if (done) done_cnt++;
            if (exp_q.size() != 0) begin
                check("addr", 64'(write_addr), 64'(exp_q[0].addr));
                check("data", 64'(writedata),  64'(exp_q[0].dat));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0: wr_ready = 1'b1;
                1: begin
                    wr_ready = (rdy_ph == 0);
                    rdy_ph   = (rdy_ph + 1) % 3;
                end
                default: wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clock);
            seen = done;
        end
        check(name, 64'(seen), 64'd1);
    endtask

    task automatic rand_inputs();
        for (int r = 0; r < SA_ROWS; r++)
            for (int c = 0; c < SA_COLS; c++) out_m[r][c] = DW'($urandom);
        base_C    = AW'($urandom);
        dim_col_C = DIMW'($urandom);
    endtask

    initial begin
        int   d0;
        logic [DW-1:0] exp_l0;

        repeat (3) @(negedge clock);
        tick();
        reset = 1'b1;
        tick();

        // Basic transfer with literal pins on first beat, last beat and done timing
        for (int r = 0; r < SA_ROWS; r++)
            for (int c = 0; c < SA_COLS; c++) out_m[r][c] = DW'(16 * r + c);
        base_C    = AW'(70);
        dim_col_C = DIMW'(8);
        rdy_mode  = 0;
        tick();
        pulse_start();
        @(negedge clock);
        check("s1_first_addr", 64'(write_addr), 64'd70);
        check("s1_first_data", 64'(writedata), 64'h0003_0002_0001_0000);
        repeat (15) @(posedge clock);
        @(negedge clock);
        check("s1_last_addr", 64'(write_addr), 64'd130);
        check("s1_last_data", 64'(writedata), 64'h0077_0076_0075_0074);
        @(negedge clock);
        check("s1_done_at_17", 64'(done), 64'd1);
        tick();

        // Backpressure 1,0,0 pattern
        rdy_mode = 1;
        tick();
        pulse_start();
        wait_done("s2_done");
        tick();

        // Stride with address wrap, then overlapping rows
        rdy_mode  = 0;
        base_C    = AW'(2 ** AW - 4);
        dim_col_C = DIMW'(10);
        tick();
        pulse_start();
        @(negedge clock);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("s3_row1_beat0", 64'(write_addr), 64'd6);
        @(posedge clock);
        @(negedge clock);
        check("s3_row1_beat1", 64'(write_addr), 64'd10);
        wait_done("s3_wrap_done");
        tick();
        dim_col_C = DIMW'(4);
        tick();
        pulse_start();
        @(negedge clock);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("s3_overlap_row1", 64'(write_addr), 64'd0);
        wait_done("s3_overlap_done");
        tick();

        // Snapshot isolation, start ignored in WRITE and in DONE
        rdy_mode = 2;
        rand_inputs();
        tick();
        d0 = done_cnt;
        pulse_start();
        repeat (3) tick();
        rand_inputs();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("s4_done");
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) tick();
        check("s4_one_done", 64'(done_cnt - d0), 64'd1);

        // Reset mid-transfer, then a clean restart
        rdy_mode  = 0;
        base_C    = AW'(100);
        dim_col_C = DIMW'(8);
        tick();
        d0 = done_cnt;
        pulse_start();
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("s5_rst_write", 64'(write), 64'd0);
        check("s5_rst_busy",  64'(busy),  64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("s5_no_done", 64'(done_cnt - d0), 64'd0);
        pulse_start();
        wait_done("s5_restart_done");
        tick();

        // ReLU lane behaviour on the first beat
        rand_inputs();
        out_m[0][0] = DW'(16'hFFFF);
        out_m[0][1] = DW'(16'h0005);
        base_C      = '0;
`ifdef WRITEBACK_RELU_EN
        exp_l0 = '0;
`else
        exp_l0 = DW'(16'hFFFF);
`endif
        tick();
        pulse_start();
        @(negedge clock);
        check("s6_lane0", 64'(writedata[0]), 64'(exp_l0));
        check("s6_lane1", 64'(writedata[1]), 64'h5);
        wait_done("s6_done");
        tick();

        // Randomized transfers under random backpressure
        rdy_mode = 2;
        for (int t = 0; t < 8; t++) begin
            rand_inputs();
            tick();
            pulse_start();
            wait_done("rand_done");
            tick();
        end
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
